// File: rtl/obi_rr_arbiter.sv
// rtl/obi_rr_arbiter.sv - round-robin OBI arbiter, NUM_MGR managers onto one subordinate
// Winner is locked while the subordinate stalls; responses are routed via an index FIFO.
module obi_rr_arbiter #(
   parameter int NUM_MGR    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_OUTST  = 2
) (
   input  logic                            clk_i,
   input  logic                            reset_ni,
   input  logic [NUM_MGR-1:0]              mgr_req_i,
   output logic [NUM_MGR-1:0]              mgr_gnt_o,
   input  logic [NUM_MGR*ADDR_WIDTH-1:0]   mgr_addr_i,
   input  logic [NUM_MGR-1:0]              mgr_we_i,
   input  logic [NUM_MGR*DATA_WIDTH/8-1:0] mgr_be_i,
   input  logic [NUM_MGR*DATA_WIDTH-1:0]   mgr_wdata_i,
   output logic [NUM_MGR-1:0]              mgr_rvalid_o,
   input  logic [NUM_MGR-1:0]              mgr_rready_i,
   output logic [DATA_WIDTH-1:0]           mgr_rdata_o,
   output logic                            mgr_err_o,
   output logic                            sbr_req_o,
   input  logic                            sbr_gnt_i,
   output logic [ADDR_WIDTH-1:0]           sbr_addr_o,
   output logic                            sbr_we_o,
   output logic [DATA_WIDTH/8-1:0]         sbr_be_o,
   output logic [DATA_WIDTH-1:0]           sbr_wdata_o,
   input  logic                            sbr_rvalid_i,
   output logic                            sbr_rready_o,
   input  logic [DATA_WIDTH-1:0]           sbr_rdata_i,
   input  logic                            sbr_err_i,
   output logic                            unexp_rsp_o
);

   localparam int BW = DATA_WIDTH / 8;
   localparam int PW = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1;
   localparam int CW = $clog2(MAX_OUTST + 1);
   localparam int FW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

   logic [PW-1:0] rr_ptr, sel_q, arb_idx, winner, head;
   logic          lock;
   logic [CW-1:0] cnt;
   logic [FW-1:0] wptr, rptr;
   logic [PW-1:0] fifo_mem [MAX_OUTST];
   logic          full, has_txn, accept, pop;

   function automatic logic [FW-1:0] next_ptr(input logic [FW-1:0] p);
      return (p == FW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
   endfunction

   // Scan downwards so the requester closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      logic [PW-1:0] idx;
      idx     = '0;
      arb_idx = rr_ptr;
      for (int k = NUM_MGR - 1; k >= 0; k--) begin
         idx = PW'((int'(rr_ptr) + k) % NUM_MGR);
         if (mgr_req_i[idx]) arb_idx = idx;
      end
   end

   assign winner  = lock ? sel_q : arb_idx;
   assign full    = (cnt == CW'(MAX_OUTST));
   assign has_txn = (cnt != '0);
   assign head    = fifo_mem[rptr];

   assign sbr_req_o   = (lock | (|mgr_req_i)) & ~full;
   assign accept      = sbr_req_o & sbr_gnt_i;
   assign sbr_addr_o  = mgr_addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
   assign sbr_we_o    = mgr_we_i[winner];
   assign sbr_be_o    = mgr_be_i[int'(winner)*BW +: BW];
   assign sbr_wdata_o = mgr_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      mgr_gnt_o         = '0;
      mgr_gnt_o[winner] = accept;
   end

   always_comb begin
      mgr_rvalid_o = '0;
      if (has_txn) mgr_rvalid_o[head] = sbr_rvalid_i;
   end

   assign sbr_rready_o = has_txn & mgr_rready_i[head];
   assign pop          = sbr_rvalid_i & sbr_rready_o;
   assign mgr_rdata_o  = sbr_rdata_i;
   assign mgr_err_o    = sbr_err_i;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rr_ptr      <= '0;
         sel_q       <= '0;
         lock        <= 1'b0;
         cnt         <= '0;
         wptr        <= '0;
         rptr        <= '0;
         unexp_rsp_o <= 1'b0;
      end else begin
         if (accept) begin
            lock   <= 1'b0;
            rr_ptr <= (winner == PW'(NUM_MGR - 1)) ? '0 : winner + 1'b1;
            wptr   <= next_ptr(wptr);
         end else if (sbr_req_o) begin
            // Subordinate stalled: hold this manager's attributes until granted.
            lock  <= 1'b1;
            sel_q <= winner;
         end
         if (pop) rptr <= next_ptr(rptr);
         if (accept && !pop) cnt <= cnt + 1'b1;
         else if (pop && !accept) cnt <= cnt - 1'b1;
         if (sbr_rvalid_i && !has_txn) unexp_rsp_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) fifo_mem[wptr] <= winner;
   end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb/tb_obi_rr_arbiter.sv - directed self-checking bench for obi_rr_arbiter
module tb_obi_rr_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req, gnt_o, we, rvalid_o, rready;
   logic [127:0] addr, wdata;
   logic [15:0]  be;
   logic [31:0]  rdata_o, sbr_addr, sbr_wdata, sbr_rdata;
   logic         err_o, sbr_req, sbr_gnt, sbr_we, sbr_rvalid, sbr_rready, sbr_err, unexp;
   logic [3:0]   sbr_be;
   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   obi_rr_arbiter dut (
      .clk_i(clk), .reset_ni(rst_n),
      .mgr_req_i(req), .mgr_gnt_o(gnt_o), .mgr_addr_i(addr), .mgr_we_i(we),
      .mgr_be_i(be), .mgr_wdata_i(wdata), .mgr_rvalid_o(rvalid_o), .mgr_rready_i(rready),
      .mgr_rdata_o(rdata_o), .mgr_err_o(err_o),
      .sbr_req_o(sbr_req), .sbr_gnt_i(sbr_gnt), .sbr_addr_o(sbr_addr), .sbr_we_o(sbr_we),
      .sbr_be_o(sbr_be), .sbr_wdata_o(sbr_wdata), .sbr_rvalid_i(sbr_rvalid),
      .sbr_rready_o(sbr_rready), .sbr_rdata_i(sbr_rdata), .sbr_err_i(sbr_err),
      .unexp_rsp_o(unexp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] r, input logic g, input logic rv,
                        input logic [3:0] rr, input logic [31:0] rd, input logic e);
      req = r; sbr_gnt = g; sbr_rvalid = rv; rready = rr; sbr_rdata = rd; sbr_err = e;
      #1;
   endtask

   initial begin
      addr  = {32'h300, 32'h200, 32'h100, 32'h0A0};
      wdata = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
      be    = {4'h1, 4'hC, 4'h3, 4'hF};
      we    = 4'b1010;
      rst_n = 1'b0;
      drive(4'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      chk("reset_req", sbr_req, 0);
      chk("reset_gnt", gnt_o, 0);
      chk("reset_rvalid", rvalid_o, 0);
      chk("reset_rready", sbr_rready, 0);
      chk("reset_unexp", unexp, 0);
      cyc();
      rst_n = 1'b1;

      // fairness: all four request, one pop per cycle after the first
      cyc(); drive(4'hF, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0);
      chk("rr_gnt0", gnt_o, 4'b0001);
      chk("rr_addr0", sbr_addr, 32'h0A0);
      cyc(); drive(4'hF, 1'b1, 1'b1, 4'hF, 32'hA1, 1'b0);
      chk("rr_gnt1", gnt_o, 4'b0010);
      chk("rr_rvalid0", rvalid_o, 4'b0001);
      chk("rr_rdata", rdata_o, 32'hA1);
      cyc(); drive(4'hF, 1'b1, 1'b1, 4'hF, 32'hA2, 1'b0);
      chk("rr_gnt2", gnt_o, 4'b0100);
      chk("rr_rvalid1", rvalid_o, 4'b0010);
      cyc(); drive(4'hF, 1'b1, 1'b1, 4'hF, 32'hA3, 1'b0);
      chk("rr_gnt3", gnt_o, 4'b1000);
      chk("rr_rvalid2", rvalid_o, 4'b0100);
      cyc(); drive(4'hF, 1'b1, 1'b1, 4'hF, 32'hA4, 1'b0);
      chk("rr_gnt0_again", gnt_o, 4'b0001);
      chk("rr_rvalid3", rvalid_o, 4'b1000);
      cyc(); drive(4'h0, 1'b1, 1'b1, 4'hF, 32'hA5, 1'b0);
      chk("drain_req", sbr_req, 0);
      chk("drain_gnt", gnt_o, 0);
      chk("drain_rvalid", rvalid_o, 4'b0001);

      // single manager 1, same-cycle grant, muxed attributes
      cyc(); drive(4'b0010, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0);
      chk("m1_addr", sbr_addr, 32'h100);
      chk("m1_gnt", gnt_o, 4'b0010);
      chk("m1_we", sbr_we, 1);
      chk("m1_be", sbr_be, 4'h3);
      chk("m1_wdata", sbr_wdata, 32'hD1);
      cyc(); drive(4'hF, 1'b1, 1'b1, 4'hF, 32'hB1, 1'b0);
      chk("m1_next_is_m2", gnt_o, 4'b0100);
      chk("m1_rvalid", rvalid_o, 4'b0010);
      cyc(); drive(4'h0, 1'b0, 1'b1, 4'hF, 32'hB2, 1'b0);
      chk("m2_rvalid", rvalid_o, 4'b0100);

      // lock: rr_ptr=3 would prefer mgr0, but stalled mgr2 keeps the slot
      cyc(); drive(4'b0100, 1'b0, 1'b0, 4'hF, 32'h0, 1'b0);
      chk("lock_req", sbr_req, 1);
      chk("lock_addr_c0", sbr_addr, 32'h200);
      chk("lock_gnt_c0", gnt_o, 0);
      cyc(); drive(4'b0101, 1'b0, 1'b0, 4'hF, 32'h0, 1'b0);
      chk("lock_addr_c1", sbr_addr, 32'h200);
      chk("lock_gnt_c1", gnt_o, 0);
      cyc(); drive(4'b0101, 1'b0, 1'b0, 4'hF, 32'h0, 1'b0);
      chk("lock_addr_c2", sbr_addr, 32'h200);
      cyc(); drive(4'b0101, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0);
      chk("lock_gnt_m2", gnt_o, 4'b0100);
      chk("lock_addr_c3", sbr_addr, 32'h200);
      cyc(); drive(4'b0001, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0);
      chk("after_lock_m0", gnt_o, 4'b0001);
      chk("after_lock_addr", sbr_addr, 32'h0A0);

      // full: two outstanding (heads mgr2 then mgr0)
      cyc(); drive(4'b0010, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0);
      chk("full_req", sbr_req, 0);
      chk("full_gnt", gnt_o, 0);
      cyc(); drive(4'b0010, 1'b1, 1'b1, 4'hF, 32'hCAFE, 1'b0);
      chk("full_rvalid", rvalid_o, 4'b0100);
      chk("full_rdata", rdata_o, 32'hCAFE);
      chk("full_rready", sbr_rready, 1);
      chk("full_pop_no_accept", sbr_req, 0);
      cyc(); drive(4'b0010, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0);
      chk("reassert_req", sbr_req, 1);
      chk("reassert_gnt", gnt_o, 4'b0010);

      // backpressure on head mgr0, error broadcast
      cyc(); drive(4'h0, 1'b0, 1'b1, 4'b1110, 32'hE0, 1'b1);
      chk("bp_rvalid", rvalid_o, 4'b0001);
      chk("bp_rready", sbr_rready, 0);
      chk("bp_err", err_o, 1);
      cyc(); drive(4'h0, 1'b0, 1'b1, 4'hF, 32'hE1, 1'b0);
      chk("bp_held_head", rvalid_o, 4'b0001);
      chk("bp_rready_up", sbr_rready, 1);
      chk("bp_err_clear", err_o, 0);
      cyc(); drive(4'h0, 1'b0, 1'b1, 4'hF, 32'hE2, 1'b0);
      chk("bp_next_head", rvalid_o, 4'b0010);

      // unexpected response with nothing outstanding
      cyc(); drive(4'h0, 1'b0, 1'b1, 4'hF, 32'hBAD, 1'b0);
      chk("unexp_rvalid", rvalid_o, 0);
      chk("unexp_rready", sbr_rready, 0);
      chk("unexp_pre", unexp, 0);
      cyc(); drive(4'h0, 1'b0, 1'b0, 4'hF, 32'h0, 1'b0);
      chk("unexp_sticky", unexp, 1);

      // reset mid-transaction: one outstanding to mgr0, mgr2 locked
      cyc(); drive(4'b0001, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0);
      chk("pre_rst_gnt", gnt_o, 4'b0001);
      cyc(); drive(4'b0100, 1'b0, 1'b0, 4'hF, 32'h0, 1'b0);
      chk("pre_rst_req", sbr_req, 1);
      cyc();
      rst_n = 1'b0;
      drive(4'h0, 1'b0, 1'b1, 4'hF, 32'h0, 1'b0);
      chk("rst_mid_req", sbr_req, 0);
      chk("rst_mid_gnt", gnt_o, 0);
      chk("rst_mid_rvalid", rvalid_o, 0);
      chk("rst_mid_rready", sbr_rready, 0);
      chk("rst_mid_unexp", unexp, 0);
      cyc();
      rst_n = 1'b1;
      drive(4'hF, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0);
      chk("post_rst_gnt", gnt_o, 4'b0001);
      cyc(); drive(4'h0, 1'b0, 1'b0, 4'hF, 32'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
